// File: rtl/mem_burst_responder_pkg.sv
// Shared types and constants for the line-fill burst responder.
// Imported by the interface, the storage array and the top.
package mem_burst_responder_pkg;

  localparam int BURST_LEN = 8;
  localparam int OFFSET_W  = 3;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int CNT_W     = 4;

  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~ADDR_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STREAM
  } state_e;

  function automatic logic [ADDR_W-1:0] line_base(
    input logic [ADDR_W-1:0] a
  );
    return a & LINE_MASK;
  endfunction

endpackage

// File: rtl/mem_burst_responder_if.sv
// Fill-request, write and burst-return signals of the responder.
// master = fill controller side, slave = responder side.
interface mem_burst_responder_if;
  import mem_burst_responder_pkg::*;

  logic              fill_req;
  logic [ADDR_W-1:0] fill_address;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;
  logic              memory_busy;
  logic              burst_done;

  modport master (
    output fill_req, fill_address,
    output wr_en, wr_address, wr_data,
    input  memory_data, memory_data_valid,
    input  memory_busy, burst_done
  );

  modport slave (
    input  fill_req, fill_address,
    input  wr_en, wr_address, wr_data,
    output memory_data, memory_data_valid,
    output memory_busy, burst_done
  );

endinterface

// File: rtl/mem_burst_responder_storage_array.sv
// Word storage: synchronous write, registered read, and
// same-edge write-to-read forwarding. Contents survive reset.
module mem_storage_array
  import mem_burst_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W-1:0] IDX_MASK =
    ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;

  // high address bits alias onto the same words
  assign wr_idx = DEPTH_LOG2'(wr_addr & IDX_MASK);
  assign rd_idx = DEPTH_LOG2'(rd_addr & IDX_MASK);

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = (wr_en && (wr_idx == rd_idx))
                ? wr_data : mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_burst_responder.sv
// Line-fill responder: waits LATENCY cycles after a fill
// request, then streams the 8 aligned words of the line.
module mem_burst_responder
  import mem_burst_responder_pkg::*;
#(
  parameter int LATENCY        = 4,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input logic                   clk,
  input logic                   rst_n,
  mem_burst_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic [ADDR_W-1:0]   line_q, line_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    line_d  = line_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    rd_en   = 1'b0;
    rd_addr = line_q | ADDR_W'(off_q);
    unique case (state_q)
      IDLE: begin
        // busy_q still high here marks the burst_done cycle
        busy_d = 1'b0;
        if (bus.fill_req && !busy_q) begin
          line_d  = line_base(bus.fill_address);
          cnt_d   = LAT_M1;
          off_d   = '0;
          busy_d  = 1'b1;
          state_d = (LATENCY == 1) ? STREAM : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = STREAM;
      end
      STREAM: begin
        rd_en   = 1'b1;
        valid_d = 1'b1;
        off_d   = off_q + 1'b1;
        if (off_q == OFFSET_W'(BURST_LEN - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      line_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  mem_storage_array #(
    .DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_address),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (bus.memory_data)
  );

  assign bus.memory_data_valid = valid_q;
  assign bus.memory_busy       = busy_q;
  assign bus.burst_done        = done_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder (LATENCY 4 and 1).
// Inputs change #1 after posedge; outputs sampled there too.
module tb_mem_burst_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] exp_w [8];

  always #5 clk = ~clk;

  mem_burst_responder_if bus0 ();
  mem_burst_responder_if bus1 ();

  mem_burst_responder #(
    .LATENCY (4), .MEM_DEPTH_LOG2 (10)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0.slave)
  );

  mem_burst_responder #(
    .LATENCY (1), .MEM_DEPTH_LOG2 (10)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int sel, input logic fr,
                     input logic [15:0] fa, input logic we,
                     input logic [15:0] wa,
                     input logic [15:0] wd);
    if (sel == 0) begin
      bus0.fill_req = fr; bus0.fill_address = fa;
      bus0.wr_en = we; bus0.wr_address = wa;
      bus0.wr_data = wd;
    end else begin
      bus1.fill_req = fr; bus1.fill_address = fa;
      bus1.wr_en = we; bus1.wr_address = wa;
      bus1.wr_data = wd;
    end
  endtask

  task automatic sample(input int sel, output logic v,
                        output logic b, output logic d,
                        output logic [15:0] q);
    if (sel == 0) begin
      v = bus0.memory_data_valid; b = bus0.memory_busy;
      d = bus0.burst_done; q = bus0.memory_data;
    end else begin
      v = bus1.memory_data_valid; b = bus1.memory_busy;
      d = bus1.burst_done; q = bus1.memory_data;
    end
  endtask

  // Issue a fill, then check every cycle up to the first idle
  // one. Optional fill_req / write injected in cycle req_k/wr_k.
  task automatic fill_burst(input string tag, input int sel,
                            input int lat,
                            input logic [15:0] addr,
                            input int req_k,
                            input logic [15:0] req_a,
                            input int wr_k,
                            input logic [15:0] wa,
                            input logic [15:0] wd);
    logic v, b, dn;
    logic [15:0] q;
    logic ev, eb, ed;
    drv(sel, 1'b1, addr, 1'b0, 16'h0, 16'h0);
    tick();
    for (int k = 0; k <= lat + 8; k++) begin
      if (k > 0) tick();
      sample(sel, v, b, dn, q);
      ev = (k >= lat) && (k <= lat + 7);
      eb = (k <= lat + 7);
      ed = (k == lat + 7);
      chk($sformatf("%s.valid%0d", tag, k), 16'(v), 16'(ev));
      chk($sformatf("%s.busy%0d", tag, k), 16'(b), 16'(eb));
      chk($sformatf("%s.done%0d", tag, k), 16'(dn), 16'(ed));
      if (ev) chk($sformatf("%s.data%0d", tag, k - lat),
                  q, exp_w[k - lat]);
      drv(sel, k == req_k, req_a, k == wr_k, wa, wd);
    end
    drv(sel, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic set_exp(input logic [15:0] b);
    for (int i = 0; i < 8; i++) exp_w[i] = b + 16'(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic v, b, dn;
    logic [15:0] q;
    rst_n = 1'b0;
    drv(0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    drv(1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();
    tick();
    sample(0, v, b, dn, q);
    chk("rst.valid", 16'(v), 16'h0);
    chk("rst.busy", 16'(b), 16'h0);
    chk("rst.done", 16'(dn), 16'h0);
    chk("rst.data", q, 16'h0);
    sample(1, v, b, dn, q);
    chk("rst1.busy", 16'(b), 16'h0);
    rst_n = 1'b1;
    tick();

    // preload 0x40..0x47 = A000.., 0x48..0x4F = C000..
    for (int i = 0; i < 16; i++) begin
      logic [15:0] d;
      d = (i < 8) ? 16'hA000 + 16'(i) : 16'hC000 + 16'(i - 8);
      drv(0, 1'b0, 16'h0, 1'b1, 16'h0040 + 16'(i), d);
      drv(1, 1'b0, 16'h0, 1'b1, 16'h0040 + 16'(i), d);
      tick();
    end
    drv(0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    drv(1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    tick();

    set_exp(16'hA000);
    fill_burst("basic", 0, 4, 16'h0043, -1, 16'h0, -1, 16'h0, 16'h0);
    fill_burst("alias", 0, 4, 16'h0443, -1, 16'h0, -1, 16'h0, 16'h0);
    fill_burst("lat1", 1, 1, 16'h0043, -1, 16'h0, -1, 16'h0, 16'h0);

    fill_burst("drop", 0, 4, 16'h0040, 7, 16'h0100, -1, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      sample(0, v, b, dn, q);
      chk($sformatf("drop.idle_valid%0d", i), 16'(v), 16'h0);
      chk($sformatf("drop.idle_busy%0d", i), 16'(b), 16'h0);
    end

    exp_w[5] = 16'hBEEF;
    fill_burst("fwd", 0, 4, 16'h0040, -1, 16'h0, 8, 16'h0045, 16'hBEEF);
    fill_burst("fwd2", 0, 4, 16'h0040, -1, 16'h0, -1, 16'h0, 16'h0);

    // abort after the third word; a fill_req rides on the reset edge
    drv(0, 1'b1, 16'h0040, 1'b0, 16'h0, 16'h0);
    tick();
    drv(0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    for (int k = 1; k <= 6; k++) tick();
    sample(0, v, b, dn, q);
    chk("abort.pre_valid", 16'(v), 16'h1);
    chk("abort.pre_data", q, 16'hA002);
    rst_n = 1'b0;
    drv(0, 1'b1, 16'h0048, 1'b0, 16'h0, 16'h0);
    tick();
    rst_n = 1'b1;
    drv(0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    sample(0, v, b, dn, q);
    chk("abort.valid", 16'(v), 16'h0);
    chk("abort.busy", 16'(b), 16'h0);
    chk("abort.done", 16'(dn), 16'h0);
    chk("abort.data", q, 16'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      sample(0, v, b, dn, q);
      chk($sformatf("abort.quiet_v%0d", i), 16'(v), 16'h0);
      chk($sformatf("abort.quiet_b%0d", i), 16'(b), 16'h0);
      chk($sformatf("abort.quiet_d%0d", i), 16'(dn), 16'h0);
    end
    fill_burst("kept", 0, 4, 16'h0040, -1, 16'h0, -1, 16'h0, 16'h0);

    // request in burst_done cycle dropped; next cycle accepted
    fill_burst("b2b_a", 0, 4, 16'h0040, 11, 16'h0048, -1, 16'h0, 16'h0);
    set_exp(16'hC000);
    fill_burst("b2b_b", 0, 4, 16'h0048, -1, 16'h0, -1, 16'h0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
